// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - 8N1 UART receiver assembling little-endian 32-bit words for ROM/RAM load
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int IDLE_BITS    = 40
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_i,
    input  logic        upg_rx_i,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        frame_err_o
);

    localparam int TW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW          = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;

    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDLE_M1 = IW'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_rx_meta;
    logic          r_rxs;
    logic [TW-1:0] r_timer;
    logic [IW-1:0] r_idle_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [1:0]    r_byte_cnt;
    logic [14:0]   r_word_cnt;
    logic          r_wen;
    logic [14:0]   r_adr;
    logic [31:0]   r_dat;
    logic          r_done;
    logic          r_frame_err;

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rxs       <= 1'b1;
            r_timer     <= '0;
            r_idle_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_word_cnt  <= '0;
            r_wen       <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta <= upg_rx_i;
            r_rxs     <= r_rx_meta;
            r_wen     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        r_state    <= S_START;
                        r_timer    <= '0;
                        r_idle_cnt <= '0;
                    end else if (r_word_cnt != 15'd0) begin
                        // Line quiet after at least one word: end of image
                        if (r_idle_cnt == IDLE_M1) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_byte_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + IW'(1);
                        end
                    end
                end
                S_START: begin
                    if (r_timer == HALF_M1) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer == FULL_M1) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                        if (r_rxs) begin
                            r_dat[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_wen <= 1'b1;
                                r_adr <= r_word_cnt;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_byte_cnt  <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Address space ends at 0x7FFF; the top word terminates the load
            if (r_wen) begin
                if (r_word_cnt == 15'h7FFF) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_word_cnt <= r_word_cnt + 15'd1;
                end
            end
        end
    end

    assign upg_wen_o   = r_wen;
    assign upg_adr_o   = r_adr;
    assign upg_dat_o   = r_dat;
    assign upg_done_o  = r_done;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - randomized bench for uart_word_loader against a byte-queue reference model
module tb_uart_word_loader;

    localparam int CPB       = 8;
    localparam int IDLE_BITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        wen;
    logic [14:0] adr;
    logic [31:0] dat;
    logic        done;
    logic        ferr;

    int n_checks = 0;
    int n_fail   = 0;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS)) dut (
        .upg_clk_i  (clk),
        .upg_rst_i  (rst),
        .upg_rx_i   (rx),
        .upg_wen_o  (wen),
        .upg_adr_o  (adr),
        .upg_dat_o  (dat),
        .upg_done_o (done),
        .frame_err_o(ferr)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the word in progress, count of completed words
    logic [7:0]  m_part[$];
    int          m_words;
    logic        m_err;
    logic        m_done;
    logic [14:0] m_last_adr;
    logic [31:0] m_last_dat;
    logic [14:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic [14:0] obs_adr[$];
    logic [31:0] obs_dat[$];
    logic        prev_wen = 1'b0;
    logic [14:0] prev_adr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wen) begin
            obs_adr.push_back(adr);
            obs_dat.push_back(dat);
            check("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
            check("done_low_during_wen", {31'd0, done}, 32'd0);
        end
        if (prev_wen && prev_adr == 15'h7FFF)
            check("done_after_top_write", {31'd0, done}, 32'd1);
        prev_wen = wen;
        prev_adr = adr;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_part.delete();
        m_words    = 0;
        m_err      = 1'b0;
        m_done     = 1'b0;
        m_last_adr = '0;
        m_last_dat = '0;
        exp_adr.delete();
        exp_dat.delete();
        obs_adr.delete();
        obs_dat.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input logic ok);
        logic [31:0] w;
        if (m_done) return;
        if (!ok) begin
            m_err = 1'b1;
            m_part.delete();
            return;
        end
        m_part.push_back(b);
        if (m_part.size() == 4) begin
            w          = {m_part[3], m_part[2], m_part[1], m_part[0]};
            m_last_adr = m_words[14:0];
            m_last_dat = w;
            exp_adr.push_back(m_last_adr);
            exp_dat.push_back(w);
            m_part.delete();
            if (m_words == 32'h7FFF) m_done = 1'b1;
            m_words++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ok, input int gap);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = ok;
        tick(CPB);
        rx = 1'b1;
        tick(gap);
        model_byte(b, ok);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, gap);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, obs_adr.size(), exp_adr.size());
        for (int i = 0; i < exp_adr.size() && i < obs_adr.size(); i++) begin
            check({tag, "_adr"}, {17'd0, obs_adr[i]}, {17'd0, exp_adr[i]});
            check({tag, "_dat"}, obs_dat[i], exp_dat[i]);
        end
        exp_adr.delete();
        exp_dat.delete();
        obs_adr.delete();
        obs_dat.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wen"},  {31'd0, wen}, 32'd0);
        check({tag, "_adr"},  {17'd0, adr}, 32'd0);
        check({tag, "_dat"},  dat, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_ferr"}, {31'd0, ferr}, 32'd0);
    endtask

    initial begin
        int          waited;
        logic [31:0] w;
        logic [7:0]  b;
        logic        ok;

        model_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(1000);
        check("idle_no_done", {31'd0, done}, 32'd0);
        check_writes("idle");

        // Short low pulse must be rejected as a false start
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check("glitch_ferr", {31'd0, ferr}, 32'd0);
        check_writes("glitch");

        send_word(32'h12345678, 8);
        check_writes("word0");
        check("word0_adr_hold", {17'd0, adr}, 32'd0);
        check("word0_dat_hold", dat, 32'h12345678);
        send_word(32'hDEADBEEF, 8);
        check_writes("word1");
        check("word1_adr_hold", {17'd0, adr}, 32'd1);

        send_byte(8'hAA, 1'b0, 8);
        check("bad_stop_ferr", {31'd0, ferr}, 32'd1);
        send_word(32'h04030201, 8);
        check_writes("after_err");
        check("after_err_dat", dat, 32'h04030201);

        for (int k = 0; k < 12; k++) begin
            w = $urandom;
            for (int i = 0; i < 4; i++) begin
                b  = w[8*i +: 8];
                ok = ($urandom_range(7, 0) != 0);
                send_byte(b, ok, $urandom_range(16, 6));
            end
            check_writes("rand");
        end
        while (m_part.size() != 0) send_byte(8'($urandom), 1'b1, 8);
        send_word($urandom, 8);
        check_writes("rand_tail");
        check("rand_adr_hold", {17'd0, adr}, {17'd0, m_last_adr});
        check("rand_dat_hold", dat, m_last_dat);
        check("rand_ferr", {31'd0, ferr}, {31'd0, m_err});

        // Idle timeout after two words with a partial third word
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(2);
        send_word($urandom, 8);
        send_word($urandom, 8);
        send_byte(8'h11, 1'b1, 8);
        send_byte(8'h22, 1'b1, 8);
        check("timeout_not_early", {31'd0, done}, 32'd0);
        waited = 0;
        while (!done && waited < 200) begin
            tick(1);
            waited++;
        end
        m_part.delete();
        m_done = 1'b1;
        check("timeout_done", {31'd0, done}, 32'd1);
        check("timeout_latency_ok", {31'd0, (waited >= 20 && waited <= 26)}, 32'd1);
        check("timeout_adr", {17'd0, adr}, 32'd1);
        check_writes("timeout");
        send_word($urandom, 8);
        check_writes("after_done");
        check("after_done_still_done", {31'd0, done}, 32'd1);

        // Top of address space
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        force dut.r_word_cnt = 15'h7FFE;
        tick(1);
        release dut.r_word_cnt;
        m_words = 32'h7FFE;
        send_word($urandom, 8);
        send_word($urandom, 8);
        check_writes("wrap");
        check("wrap_done", {31'd0, done}, 32'd1);
        check("wrap_adr", {17'd0, adr}, 32'h7FFF);
        send_byte(8'h5A, 1'b1, 8);
        check_writes("wrap_ignored");

        // Reset in the middle of a byte
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        rx = 1'b0;
        tick(CPB / 2);
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check_outputs_zero("midbyte_reset");
        rst = 1'b0;
        model_reset();
        tick(2);
        send_word($urandom, 8);
        check_writes("restart");
        check("restart_adr", {17'd0, adr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- UART programming front end: receives an 8N1 serial stream on upg_rx_i and assembles little-endian bytes into 32-bit words.
- Emits one write pulse per word, with a 15-bit word address, to programrom and dmemory32. Top level gates the write with upg_adr_o[14]: 0 = instruction ROM, 1 = data RAM.
- Signals load completion so the top level can release the CPU from reset.
- Sits directly upstream of programrom/dmemory32, on the UART programmer clock domain.

Parameters:
- CLKS_PER_BIT, 87, upg_clk_i cycles per UART bit (10 MHz / 115200).
- IDLE_BITS, 40, idle-line bit periods after the last word before done is declared.

Ports:
- upg_clk_i  input  1  loader clock; all logic on its rising edge.
- upg_rst_i  input  1  synchronous active-high reset.
- upg_rx_i  input  1  UART serial input, idle high, asynchronous.
- upg_wen_o  output  1  one-cycle write strobe.
- upg_adr_o  output  15  word address of the current or last write.
- upg_dat_o  output  32  assembled word.
- upg_done_o  output  1  load complete, sticky.
- frame_err_o  output  1  stop-bit error seen, sticky.

Behaviour:
- Reset: registers load on the upg_clk_i edge while upg_rst_i=1.
  - All outputs go to 0; the rx synchronizer goes to 1.
  - FSM goes to IDLE; byte_cnt=0, word_cnt=0, idle counter=0.
  - Reset mid-frame or mid-word discards all partial data.
- Input sync: upg_rx_i passes through a 2-flop synchronizer; only the synchronized value (rxs) is used.
- FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: rxs=0 → START with bit timer cleared.
  - START: at timer = CLKS_PER_BIT/2-1, rxs is resampled. If rxs=0 → DATA with timer cleared. If rxs=1, the glitch is rejected → IDLE.
  - DATA: sample every CLKS_PER_BIT cycles from the mid-bit point; 8 bits, LSB first, shifted into the byte register. After bit 7 → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1: byte accepted.
    - rxs=0: frame_err_o<=1, partial word discarded (byte_cnt<=0), wen not asserted.
    - Either way → IDLE.
- Byte assembly:
  - Accepted byte k (k = byte_cnt, 0..3) is written into upg_dat_o[8k+7:8k].
  - byte_cnt increments and wraps 3→0.
  - On the 4th byte, the cycle after the STOP sample:
    - upg_wen_o=1 for exactly one cycle.
    - upg_adr_o = word_cnt[14:0], upg_dat_o = full word. Both stay stable through the wen cycle and hold until the next write.
  - word_cnt increments in the cycle after wen.
  - upg_dat_o bytes update in place during assembly; consumers sample only on wen.
- Address wrap: after the write to 0x7FFF, FSM → DONE and upg_done_o=1 in the following cycle. No wrap to 0.
- Idle timeout:
  - Counter runs only in IDLE with rxs=1 and word_cnt>0. It clears on entry to START.
  - At IDLE_BITS*CLKS_PER_BIT cycles: a partial word (byte_cnt≠0) is discarded; FSM → DONE; upg_done_o=1.
  - With word_cnt=0 the counter never runs; the block waits indefinitely.
- DONE: upg_rx_i is ignored; upg_wen_o stays 0; outputs hold. Exit only via reset.
- Simultaneous events: reset dominates. Timeout cannot coincide with a write, because the counter is not running outside IDLE.
- Throughput: a 10-bit frame takes ≥10*CLKS_PER_BIT cycles; wen pulses are at least ~40*CLKS_PER_BIT apart.

Test Plan (CLKS_PER_BIT=8, IDLE_BITS=4):
- Reset held 3 cycles, rx=1 → all outputs 0. Release, leave rx idle 1000 cycles → upg_done_o stays 0, no wen.
- Send bytes 0x78,0x56,0x34,0x12 → single wen pulse with upg_adr_o=0x0000, upg_dat_o=0x12345678. Next word 0xDEADBEEF sent as EF,BE,AD,DE → adr 0x0001.
- 3-cycle low glitch on rx in IDLE → no byte accepted, byte_cnt unchanged, frame_err_o=0.
- Byte 0xAA with stop bit 0, then 4 good bytes 01,02,03,04 → frame_err_o=1; wen with upg_dat_o=0x04030201 at the next sequential address.
- After 2 words, send 2 bytes then idle 32 cycles → upg_done_o=1, no third wen, upg_adr_o=0x0001. Further rx traffic is ignored.
- Preload word_cnt near the top (force, or stream 32768 words in a long run) → last wen has adr 0x7FFF, upg_done_o=1 the next cycle. Reset mid-byte of a later run → clean restart at adr 0.
